tempo_gen: RTL and testbench

Converts the user-loaded tempo (BPM, quarter notes per minute) into the eighth-note beat clock that drives the sequencer's 8-step loop. Sits directly upstream of the sequencer control FSM. It takes that FSM's `ld_bpm` strobe and `play` enable and produces its `slow_clk`. The division to a cycle count is done by an iterative sequential divider, so no combinational divider is needed.

---
 rtl/tempo_pkg.sv | 27 ++
 rtl/seq_divider.sv | 72 +++++++
 rtl/tempo_gen.sv | 102 ++++++++++
 tb/tb_tempo_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/tempo_pkg.sv
// Shared widths and elaboration-time helpers for the tempo generator.
package tempo_pkg;

   localparam int DIV_W = 32;
   localparam int BPM_W = 8;

   function automatic logic [BPM_W-1:0] bpm_clamp(
      input logic [BPM_W-1:0] raw,
      input logic [BPM_W-1:0] lo,
      input logic [BPM_W-1:0] hi
   );
      if (raw < lo) return lo;
      if (raw > hi) return hi;
      return raw;
   endfunction

   // Eighth-note period in clk cycles: clk_hz*60 / (2*bpm), truncated.
   function automatic logic [DIV_W-1:0] reset_period(
      input longint unsigned clk_hz,
      input longint unsigned bpm
   );
      longint unsigned cycles;
      cycles = (clk_hz * 30) / bpm;
      return cycles[DIV_W-1:0];
   endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, DIV_W cycles per divide.
module seq_divider #(
   parameter int DIV_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [DIV_W-1:0] num,
   input  logic [DIV_W-1:0] den,
   output logic             busy,
   output logic             done,
   output logic [DIV_W-1:0] quot
);

   localparam int CNT_W = $clog2(DIV_W + 1);

   logic [DIV_W-1:0] q_r;
   logic [DIV_W-1:0] rem_r;
   logic [DIV_W-1:0] den_r;
   logic [CNT_W-1:0] iter;
   logic [DIV_W:0]   rem_sh;
   logic [DIV_W:0]   diff;
   logic [DIV_W-1:0] q_next;
   logic [DIV_W-1:0] rem_next;

   // NOTE: combinational block uses blocking assignments and assigns every output first, so no latch is inferred.
   always_comb begin
      rem_sh   = {rem_r, q_r[DIV_W-1]};
      diff     = rem_sh - {1'b0, den_r};
      rem_next = diff[DIV_W-1:0];
      q_next   = {q_r[DIV_W-2:0], 1'b1};
      if (diff[DIV_W]) begin
         rem_next = rem_sh[DIV_W-1:0];
         q_next   = {q_r[DIV_W-2:0], 1'b0};
      end
   end

   // The final iteration's quotient is presented combinationally so the
   // consumer can capture it on the same edge busy falls.
   assign done = busy && !abort && (iter == CNT_W'(DIV_W - 1));
   assign quot = q_next;

   // NOTE: sequential state uses non-blocking assignments; only control state is reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         busy <= 1'b0;
         iter <= '0;
      end else if (abort) begin
         busy <= 1'b0;
      end else if (start) begin
         busy <= 1'b1;
         iter <= '0;
      end else if (busy) begin
         iter <= iter + CNT_W'(1);
         if (done) busy <= 1'b0;
      end
   end

   // NOTE: datapath registers carry no reset; busy gates every use of them.
   always_ff @(posedge clk) begin
      if (start && !abort) begin
         q_r   <= num;
         rem_r <= '0;
         den_r <= den;
      end else if (busy) begin
         q_r   <= q_next;
         rem_r <= rem_next;
      end
   end

endmodule

// File: rtl/tempo_gen.sv
// Turns a loaded BPM into the eighth-note beat clock for the 8-step sequencer.
module tempo_gen
   import tempo_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned BPM_MIN     = 40,
   parameter int unsigned BPM_MAX     = 240,
   parameter int unsigned DEFAULT_BPM = 120
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_bpm,
   input  logic [BPM_W-1:0] bpm_in,
   input  logic             run,
   output logic             slow_clk,
   output logic             beat_tick,
   output logic [BPM_W-1:0] bpm_q,
   output logic             busy,
   output logic             period_valid
);

   localparam longint unsigned NUM_WIDE  = longint'(CLK_HZ) * 30;
   localparam logic [DIV_W-1:0] DIV_NUM   = NUM_WIDE[DIV_W-1:0];
   localparam logic [DIV_W-1:0] RST_PERIOD = reset_period(CLK_HZ, DEFAULT_BPM);

   if (NUM_WIDE > 64'hFFFF_FFFF) begin : g_clk_hz_too_big
      $error("tempo_gen: CLK_HZ*30 must fit in 32 bits");
   end

   logic             ld_q;
   logic             div_start;
   logic             div_done;
   logic [DIV_W-1:0] div_quot;
   logic [DIV_W-1:0] period;
   logic [DIV_W-1:0] pending_period;
   logic             pend_flag;
   logic [DIV_W-1:0] count;
   logic             wrap;
   logic             commit;

   assign div_start = ld_q && !ld_bpm;
   assign wrap      = (count == period - DIV_W'(1));
   // While playing, a new period only lands at a beat boundary.
   assign commit    = pend_flag && (!run || wrap);

   seq_divider #(.DIV_W(DIV_W)) u_div (
      .clk   (clk),
      .reset (reset),
      .start (div_start),
      .abort (ld_bpm),
      .num   (DIV_NUM),
      .den   (DIV_W'(bpm_q)),
      .busy  (busy),
      .done  (div_done),
      .quot  (div_quot)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         ld_q         <= 1'b0;
         bpm_q        <= BPM_W'(DEFAULT_BPM);
         period_valid <= 1'b1;
      end else begin
         ld_q <= ld_bpm;
         if (ld_bpm) begin
            bpm_q        <= bpm_clamp(bpm_in, BPM_W'(BPM_MIN), BPM_W'(BPM_MAX));
            period_valid <= 1'b0;
         end else if (div_done) begin
            period_valid <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         period         <= RST_PERIOD;
         pending_period <= '0;
         pend_flag      <= 1'b0;
      end else begin
         if (commit) period <= pending_period;
         if (div_done) begin
            pending_period <= div_quot;
            pend_flag      <= 1'b1;
         end else if (commit) begin
            pend_flag <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset || !run) begin
         count     <= '0;
         slow_clk  <= 1'b0;
         beat_tick <= 1'b0;
      end else begin
         count     <= wrap ? '0 : count + DIV_W'(1);
         slow_clk  <= (count < (period >> 1));
         beat_tick <= (count == '0);
      end
   end

endmodule

// File: tb/tb_tempo_gen.sv
// Randomized self-checking bench for tempo_gen against a BPM-to-period reference model.
module tb_tempo_gen;

   localparam int unsigned CLK_HZ = 2400;
   localparam int          NUM    = CLK_HZ * 30;

   logic       clk = 1'b0;
   logic       reset;
   logic       ld_bpm;
   logic [7:0] bpm_in;
   logic       run;
   logic       slow_clk;
   logic       beat_tick;
   logic [7:0] bpm_q;
   logic       busy;
   logic       period_valid;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int model_bpm;

   tempo_gen #(.CLK_HZ(CLK_HZ)) dut (
      .clk          (clk),
      .reset        (reset),
      .ld_bpm       (ld_bpm),
      .bpm_in       (bpm_in),
      .run          (run),
      .slow_clk     (slow_clk),
      .beat_tick    (beat_tick),
      .bpm_q        (bpm_q),
      .busy         (busy),
      .period_valid (period_valid)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int clamp_ref(input int v);
      if (v < 40) return 40;
      if (v > 240) return 240;
      return v;
   endfunction

   function automatic int exp_period(input int bpm);
      return NUM / bpm;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic load_begin(input int v);
      ld_bpm = 1'b1;
      bpm_in = 8'(v);
      step();
      model_bpm = clamp_ref(v);
      check("load_bpm_q", int'(bpm_q), model_bpm);
      check("load_valid_low", int'(period_valid), 0);
      check("load_busy_low", int'(busy), 0);
   endtask

   task automatic finish_divide(input string tag);
      int n = 0;
      ld_bpm = 1'b0;
      step();
      while (busy && n < 64) begin
         n++;
         step();
      end
      check({tag, "_busy_cycles"}, n, 32);
      check({tag, "_valid"}, int'(period_valid), 1);
   endtask

   task automatic start_run(input string tag);
      run = 1'b1;
      step();
      check({tag, "_first_tick"}, int'(beat_tick), 1);
      check({tag, "_first_slow"}, int'(slow_clk), 1);
   endtask

   task automatic stop_run(input string tag);
      run = 1'b0;
      step();
      check({tag, "_stop_slow"}, int'(slow_clk), 0);
      check({tag, "_stop_tick"}, int'(beat_tick), 0);
   endtask

   // Starts on a beat_tick cycle; each beat must last exp_p cycles, half of them high.
   task automatic measure(input string tag, input int exp_p, input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         int len = 0;
         int hi  = 0;
         do begin
            if (slow_clk) hi++;
            len++;
            step();
         end while (!beat_tick && len < 4000);
         check({tag, "_spacing"}, len, exp_p);
         check({tag, "_high"}, hi, exp_p / 2);
      end
   endtask

   initial begin
      int t0;
      int a;
      int b;
      reset  = 1'b0;
      ld_bpm = 1'b0;
      bpm_in = 8'd0;
      run    = 1'b0;
      repeat (3) step();
      check("rst_bpm_q", int'(bpm_q), 120);
      check("rst_valid", int'(period_valid), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_slow", int'(slow_clk), 0);
      check("rst_tick", int'(beat_tick), 0);
      reset = 1'b1;
      step();
      model_bpm = 120;

      start_run("def");
      measure("def", exp_period(model_bpm), 2);
      stop_run("def");

      load_begin(0);
      finish_divide("lo");
      step();
      start_run("lo");
      measure("lo", exp_period(model_bpm), 2);
      stop_run("lo");

      load_begin(255);
      finish_divide("hi");
      step();
      start_run("hi");
      measure("hi", exp_period(model_bpm), 2);
      stop_run("hi");

      // New tempo loaded mid-beat must not cut the current beat short.
      load_begin(120);
      finish_divide("w120");
      step();
      start_run("wrap");
      t0 = cyc;
      repeat (100) step();
      load_begin(60);
      finish_divide("w60");
      while (!beat_tick && cyc - t0 < 2000) step();
      check("wrap_old_beat", cyc - t0, 600);
      measure("wrap_new", exp_period(model_bpm), 2);
      stop_run("wrap");

      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      load_begin(a);
      ld_bpm = 1'b0;
      step();
      check("abort_busy_on", int'(busy), 1);
      repeat (9) step();
      load_begin(b);
      finish_divide("abort");
      step();
      start_run("abort");
      measure("abort", exp_period(model_bpm), 1);
      stop_run("abort");

      // Load arriving on the divider's last cycle wins over its result.
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      load_begin(a);
      ld_bpm = 1'b0;
      step();
      repeat (31) step();
      check("last_busy_on", int'(busy), 1);
      load_begin(b);
      finish_divide("last");
      step();
      start_run("last");
      measure("last", exp_period(model_bpm), 1);
      stop_run("last");

      load_begin(int'($urandom_range(0, 255)));
      ld_bpm = 1'b0;
      step();
      repeat (4) step();
      reset = 1'b0;
      step();
      check("rstdiv_busy", int'(busy), 0);
      check("rstdiv_bpm_q", int'(bpm_q), 120);
      check("rstdiv_valid", int'(period_valid), 1);
      reset = 1'b1;
      step();
      check("rstdiv_busy_after", int'(busy), 0);
      model_bpm = 120;
      start_run("rstdiv");
      measure("rstdiv", exp_period(model_bpm), 1);
      stop_run("rstdiv");

      start_run("mid");
      repeat (149) step();
      check("mid_slow_before", int'(slow_clk), 1);
      stop_run("mid");
      repeat (3) step();
      start_run("mid_re");
      measure("mid_re", exp_period(model_bpm), 1);
      stop_run("mid_re");

      for (int i = 0; i < 4; i++) begin
         load_begin(int'($urandom_range(0, 255)));
         finish_divide("rnd");
         step();
         start_run("rnd");
         measure("rnd", exp_period(model_bpm), 1);
         stop_run("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
